// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile -- 32 x 32-bit register file with two registered read ports, a
// writeback port with read bypass, and a per-register 2-bit pending-write
// scoreboard used by decode to detect in-flight writes.
//
// Ports
//   clk_in        : clock, all state changes on the rising edge
//   rst_in        : synchronous active-high reset (wins over rdy_in)
//   rdy_in        : global ready, 0 freezes all state and registered outputs
//   write_enable  : writeback request
//   write_addr    : writeback destination register
//   write_data    : writeback value
//   re1, re2      : read-port enables
//   raddr1, raddr2: read-port source registers
//   rdata1, rdata2: registered read data (1-cycle latency)
//   busy1, busy2  : registered flag, source register has an in-flight write
//   issue_enable  : decode issues an instruction that writes issue_addr
//   issue_addr    : destination of the issued instruction
//   sb_full       : combinational, pending count of issue_addr is saturated
// ---------------------------------------------------------------------------
module regfile (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        write_enable,
  input  logic [4:0]  write_addr,
  input  logic [31:0] write_data,
  input  logic        re1,
  input  logic        re2,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic        busy1,
  output logic        busy2,
  input  logic        issue_enable,
  input  logic [4:0]  issue_addr,
  output logic        sb_full
);

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;
  localparam int unsigned CW   = 2;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [DW-1:0] r_regs [NREG];
  logic [CW-1:0] r_cnt  [NREG];

  logic          w_wr;
  logic          w_iss;
  logic [CW-1:0] w_cnt_nxt [NREG];
  logic [DW-1:0] w_rdata1;
  logic [DW-1:0] w_rdata2;
  logic          w_busy1;
  logic          w_busy2;

  // Register 0 is never written nor tracked.
  assign w_wr  = write_enable && (write_addr != '0);
  assign w_iss = issue_enable && (issue_addr != '0);

  // Read data: zero when disabled or x0, bypass from writeback, else array.
  function automatic logic [DW-1:0] f_rdata(input logic          re,
                                            input logic [AW-1:0] ra);
    logic [DW-1:0] v;
    v = '0;
    if (re && (ra != '0)) begin
      if (write_enable && (write_addr == ra)) v = write_data;
      else                                    v = r_regs[ra];
    end
    return v;
  endfunction

  // Busy uses the count before this cycle's issue; the last outstanding
  // write retiring this cycle (with no same-address issue) clears it.
  function automatic logic f_busy(input logic          re,
                                  input logic [AW-1:0] ra);
    logic retire;
    retire = w_wr && (write_addr == ra) && !(w_iss && (issue_addr == ra));
    return re && (ra != '0) && (r_cnt[ra] != '0) &&
           !((r_cnt[ra] == CW'(1)) && retire);
  endfunction

  always_comb begin
    w_rdata1 = f_rdata(re1, raddr1);
    w_rdata2 = f_rdata(re2, raddr2);
    w_busy1  = f_busy(re1, raddr1);
    w_busy2  = f_busy(re2, raddr2);
  end

  // Scoreboard next state: issue increments, writeback decrements, both to
  // the same register cancel; saturate at 3 and hold at 0.
  always_comb begin
    for (int i = 0; i < int'(NREG); i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_iss && (issue_addr == AW'(i)) &&
          !(w_wr && (write_addr == AW'(i)))) begin
        if (r_cnt[i] != CNT_MAX) w_cnt_nxt[i] = r_cnt[i] + CW'(1);
      end else if (w_wr && (write_addr == AW'(i)) &&
                   !(w_iss && (issue_addr == AW'(i)))) begin
        if (r_cnt[i] != '0) w_cnt_nxt[i] = r_cnt[i] - CW'(1);
      end
    end
  end

  assign sb_full = (issue_addr != '0) && (r_cnt[issue_addr] == CNT_MAX);

  // State and registered outputs; reset wins over ready and any request.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(NREG); i++) begin
        r_regs[i] <= '0;
        r_cnt[i]  <= '0;
      end
      rdata1 <= '0;
      rdata2 <= '0;
      busy1  <= 1'b0;
      busy2  <= 1'b0;
    end else if (rdy_in) begin
      if (w_wr) r_regs[write_addr] <= write_data;
      for (int i = 0; i < int'(NREG); i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      rdata1 <= w_rdata1;
      rdata2 <= w_rdata2;
      busy1  <= w_busy1;
      busy2  <= w_busy2;
    end
  end

endmodule
